// File: rtl/prefix_subtractor_pipe.sv
// Three-stage pipelined subtractor A - B - Bin built as A + ~B + ~Bin on a Kogge-Stone carry network.
// Latency 3 cycles; valid/ready handshake, each stage advances when the one below is empty or moving.
module prefix_subtractor_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Diff,
  output logic             BorrowOut,
  output logic             Overflow
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic             s1_cin;
  logic             s1_a_msb;
  logic             s1_b_msb;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_p;
  logic [WIDTH:0]   s2_c;
  logic             s2_a_msb;
  logic             s2_b_msb;

  logic             s3_valid;

  logic             s1_free;
  logic             s2_free;
  logic             s3_free;

  logic [WIDTH-1:0] ks_g;
  logic [WIDTH-1:0] ks_p;
  logic [WIDTH-1:0] nxt_g;
  logic [WIDTH-1:0] nxt_p;
  logic [WIDTH-1:0] s3_diff;

  // A stage can take new data when it is empty or its content moves down this edge.
  assign s3_free  = !s3_valid || OutReady;
  assign s2_free  = !s2_valid || s3_free;
  assign s1_free  = !s1_valid || s2_free;
  assign InReady  = !RST && s1_free;
  assign OutValid = s3_valid;

  // Carry-in folds into bit 0's generate, so the prefix G of bits [i:0] is the carry into bit i+1.
  always_comb begin
    ks_g    = s1_g;
    ks_p    = s1_p;
    ks_g[0] = s1_g[0] | (s1_p[0] & s1_cin);
    nxt_g   = '0;
    nxt_p   = '0;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      nxt_g = ks_g;
      nxt_p = ks_p;
      for (int i = d; i < WIDTH; i++) begin
        nxt_g[i] = ks_g[i] | (ks_p[i] & ks_g[i-d]);
        nxt_p[i] = ks_p[i] & ks_p[i-d];
      end
      ks_g = nxt_g;
      ks_p = nxt_p;
    end
  end

  assign s3_diff = s2_p ^ s2_c[WIDTH-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_cin   <= 1'b0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else if (s1_free) begin
      s1_valid <= InValid;
      if (InValid) begin
        s1_g     <= A & ~B;
        s1_p     <= A ^ ~B;
        s1_cin   <= ~Bin;
        s1_a_msb <= A[WIDTH-1];
        s1_b_msb <= B[WIDTH-1];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_c     <= '0;
      s2_a_msb <= 1'b0;
      s2_b_msb <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p     <= s1_p;
        s2_c     <= {ks_g, s1_cin};
        s2_a_msb <= s1_a_msb;
        s2_b_msb <= s1_b_msb;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s3_valid  <= 1'b0;
      Diff      <= '0;
      BorrowOut <= 1'b0;
      Overflow  <= 1'b0;
    end else if (s3_free) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        Diff      <= s3_diff;
        BorrowOut <= ~s2_c[WIDTH];
        Overflow  <= (s2_a_msb != s2_b_msb) && (s3_diff[WIDTH-1] != s2_a_msb);
      end
    end
  end

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Directed and randomized bench for prefix_subtractor_pipe (WIDTH=8) with an arithmetic reference queue.
module tb_prefix_subtractor_pipe;

  logic       CLK = 1'b0;
  logic       RST;
  logic       InValid;
  logic       InReady;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] Diff;
  logic       BorrowOut;
  logic       Overflow;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   in_count = 0;

  prefix_subtractor_pipe #(.WIDTH(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Diff     (Diff),
    .BorrowOut(BorrowOut),
    .Overflow (Overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Plain integer arithmetic: unsigned result for Diff/borrow, signed range for overflow.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t e;
    int   u;
    int   s;
    u    = int'(a) - int'(b) - int'(bin);
    s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
    e.d  = u[7:0];
    e.bo = (u < 0);
    e.ov = (s < -128) || (s > 127);
    return e;
  endfunction

  // Scoreboard: every cycle a result is shown it must equal the oldest pending one.
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
    end else begin
      if (OutValid) begin
        chk("pending_for_out", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("diff_q", Diff, exp_q[0].d);
          chk("borrow_q", BorrowOut, exp_q[0].bo);
          chk("ovf_q", Overflow, exp_q[0].ov);
          if (OutReady) void'(exp_q.pop_front());
        end
      end
      if (InValid && InReady) begin
        exp_q.push_back(model(A, B, Bin));
        in_count++;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic ok;
    int   n;
    A       = a;
    B       = b;
    Bin     = bin;
    InValid = 1'b1;
    n       = 0;
    do begin
      @(negedge CLK);
      ok = InReady;
      @(posedge CLK);
      #1;
      n++;
    end while (!ok && n < 50);
    InValid = 1'b0;
    chk("send_accept", ok, 1);
  endtask

  task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    send(a, b, bin);
    n = 1;
    while (!OutValid && n < 10) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("latency", n, 3);
    chk("dir_diff", Diff, ed);
    chk("dir_borrow", BorrowOut, eb);
    chk("dir_ovf", Overflow, eo);
  endtask

  task automatic drain();
    int n;
    OutReady = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || OutValid) && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    RST      = 1'b1;
    InValid  = 1'b0;
    A        = '0;
    B        = '0;
    Bin      = 1'b0;
    OutReady = 1'b0;

    #3;
    chk("rst_outvalid", OutValid, 0);
    chk("rst_inready", InReady, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_borrow", BorrowOut, 0);
    chk("rst_ovf", Overflow, 0);
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("idle_inready", InReady, 1);
    chk("idle_outvalid", OutValid, 0);
    @(posedge CLK);
    #1;

    OutReady = 1'b1;
    directed(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    directed(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    directed(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
    directed(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    directed(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    drain();

    // Fill against a stalled consumer, then release with a simultaneous in/out transfer.
    OutReady = 1'b0;
    send(8'h31, 8'h12, 1'b0);
    send(8'h02, 8'h40, 1'b1);
    send(8'h90, 8'h20, 1'b0);
    chk("full_inready", InReady, 0);
    A       = 8'hC3;
    B       = 8'h3C;
    Bin     = 1'b1;
    InValid = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("stall_inready", InReady, 0);
      chk("stall_outvalid", OutValid, 1);
    end
    @(posedge CLK);
    #1;
    OutReady = 1'b1;
    send(8'hC3, 8'h3C, 1'b1);
    send(8'h7E, 8'h81, 1'b0);
    drain();

    // Reset with two operations in flight.
    send(8'h44, 8'h11, 1'b0);
    send(8'h55, 8'h22, 1'b1);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midrst_outvalid", OutValid, 0);
    chk("midrst_inready", InReady, 0);
    chk("midrst_diff", Diff, 0);
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b0;
    repeat (6) begin
      @(posedge CLK);
      #1;
      chk("post_rst_quiet", OutValid, 0);
    end
    directed(8'h20, 8'h08, 1'b1, 8'h17, 1'b0, 1'b0);
    drain();

    // Random traffic with random back-pressure.
    begin
      int cyc;
      cyc      = 0;
      in_count = 0;
      while (in_count < 10000 && cyc < 40000) begin
        InValid  = ($urandom_range(0, 3) != 0);
        A        = 8'($urandom);
        B        = 8'($urandom);
        Bin      = 1'($urandom);
        OutReady = ($urandom_range(0, 3) != 0);
        @(posedge CLK);
        #1;
        cyc++;
      end
      InValid = 1'b0;
      chk("random_transfers", 32'(in_count >= 10000), 1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
